// File: rtl/aes_subshift_iter.sv
// Iterative AES SubBytes + ShiftRows stage.
// Produces COLS_PER_CYCLE substituted, row-shifted columns per clock.
module aes_subshift_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [1:0] CPC      = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         live_q;
    logic [127:0] din_q;
    logic [127:0] dout_d;
    logic         accept;
    logic [1:0]   c;
    logic [1:0]   src;

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready  = live_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_ready && in_valid && !flush;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dout_d  = out_data;
        c       = 2'd0;
        src     = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    col_d   = 2'd0;
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    c = col_q + 2'(k);
                    for (int r = 0; r < 4; r++) begin
                        src = c + 2'(r);
                        dout_d[8*(15-4*int'(c)-r) +: 8] =
                            SBOX[din_q[8*(15-4*int'(src)-r) +: 8]];
                    end
                end
                col_d = col_q + CPC;
                if (col_q == LAST_COL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything and leaves out_data untouched
        if (flush) begin
            state_d = IDLE;
            col_d   = 2'd0;
            dout_d  = out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= 2'd0;
            live_q   <= 1'b0;
            din_q    <= '0;
            out_data <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            live_q   <= 1'b1;
            out_data <= dout_d;
            if (accept) begin
                din_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_aes_subshift_iter.sv
// Bench for aes_subshift_iter: directed vectors, corner sequences, random run.
// The reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_subshift_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, flush;
    logic         in_valid, out_ready;
    logic [127:0] in_data;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    logic         in_valid2, out_ready2, in_ready2, out_valid2, busy2;
    logic [127:0] out_data2;
    logic         in_valid4, out_ready4, in_ready4, out_valid4, busy4;
    logic [127:0] out_data4;

    aes_subshift_iter #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    aes_subshift_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .busy(busy2)
    );

    aes_subshift_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .busy(busy4)
    );

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                    ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_ss(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = sb[s[127-32*((c+r)%4)-8*r -: 8]];
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_block(input logic [127:0] d, output int lat,
                             output logic [127:0] res);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0;
            lat = -1;
            res = '0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
    endtask

    vec_t         vecs [5];
    int           lat, l1, l2, l4;
    logic [127:0] res, r1, r2, r4, prev, dhold, dnew;
    logic         ok_v, ok_d, ok_r;
    logic [127:0] q [$];
    int           acc_n, pop_n, cyc;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    initial begin
        vecs[0] = '{FIPS_IN, FIPS_OUT};
        vecs[1] = '{128'h0, {16{8'h63}}};
        vecs[2] = '{{16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{{16{8'h01}}, {16{8'h7c}}};
        vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h636b6776f201ab7b30d777c5fe7c6f2b};

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_data = '0;
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        build_sbox();

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 128'(in_ready), 128'd0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", 128'(in_ready), 128'd1);

        // directed table
        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i].din, lat, res);
            chk($sformatf("vec%0d_data", i), res, vecs[i].dout);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd4);
        end
        @(negedge clk);
        chk("post_hs_out_valid", 128'(out_valid), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready), 128'd1);

        // back-pressure hold, then pulse
        out_ready = 1'b0;
        run_block(vecs[4].din, lat, res);
        dhold = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        dnew  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        in_valid = 1'b1;
        in_data  = dhold;
        ok_v = 1'b1;
        ok_d = 1'b1;
        ok_r = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (!out_valid) ok_v = 1'b0;
            if (out_data !== vecs[4].dout) ok_d = 1'b0;
            if (in_ready) ok_r = 1'b0;
        end
        chk("hold_out_valid", 128'(ok_v), 128'd1);
        chk("hold_out_data", 128'(ok_d), 128'd1);
        chk("hold_in_ready_low", 128'(ok_r), 128'd1);
        out_ready = 1'b1;
        in_data = dnew;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pulse_idle_out_valid", 128'(out_valid), 128'd0);
        chk("pulse_idle_in_ready", 128'(in_ready), 128'd1);
        chk("pulse_idle_busy", 128'(busy), 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next_accept_busy", 128'(busy), 128'd1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("next_accept_data", out_data, ref_ss(dnew));
        chk("next_accept_lat", 128'(lat), 128'd4);
        prev = ref_ss(dnew);
        out_ready = 1'b1;

        // flush in the 2nd BUSY cycle
        run_block(128'h0, lat, res);
        chk("pre_flush_data", res, {16{8'h63}});
        prev = res;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = FIPS_IN;
        while (!in_ready) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        chk("flush_busy", 128'(busy), 128'd0);
        chk("flush_out_data_kept", out_data, {FIPS_OUT[127:96], prev[95:0]});
        run_block(FIPS_IN, lat, res);
        chk("after_flush_data", res, FIPS_OUT);
        chk("after_flush_lat", 128'(lat), 128'd4);

        // flush with in_valid in IDLE is not an accept
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_no_accept", 128'(busy), 128'd0);

        // async reset mid-BUSY
        @(negedge clk);
        in_valid = 1'b1;
        in_data = vecs[4].din;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_out_data", out_data, 128'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_in_ready", 128'(in_ready), 128'd0);
        run_block(FIPS_IN, lat, res);
        chk("after_arst_data", res, FIPS_OUT);

        // CPC 1/2/4 latency with zero input
        @(negedge clk);
        in_data = '0;
        in_valid = 1'b1;
        in_valid2 = 1'b1;
        in_valid4 = 1'b1;
        chk("cpc_all_ready", 128'({in_ready, in_ready2, in_ready4}), 128'd7);
        @(negedge clk);
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        l1 = -1;
        l2 = -1;
        l4 = -1;
        r1 = '0;
        r2 = '0;
        r4 = '0;
        for (int t = 0; t < 8; t++) begin
            if (out_valid && l1 < 0) begin l1 = t; r1 = out_data; end
            if (out_valid2 && l2 < 0) begin l2 = t; r2 = out_data2; end
            if (out_valid4 && l4 < 0) begin l4 = t; r4 = out_data4; end
            @(negedge clk);
        end
        chk("cpc1_lat", 128'(l1), 128'd4);
        chk("cpc2_lat", 128'(l2), 128'd2);
        chk("cpc4_lat", 128'(l4), 128'd1);
        chk("cpc1_data", r1, {16{8'h63}});
        chk("cpc2_data", r2, {16{8'h63}});
        chk("cpc4_data", r4, {16{8'h63}});

        // random back-to-back with random out_ready
        acc_n = 0;
        pop_n = 0;
        cyc = 0;
        while (pop_n < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid = (acc_n < 1000);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                acc_n++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_extra_output", 128'd1, 128'd0);
                end else begin
                    chk($sformatf("rand_blk%0d", pop_n), out_data,
                        ref_ss(q.pop_front()));
                end
                pop_n++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_count", 128'(pop_n), 128'd1000);
        chk("rand_queue_empty", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
